sync_debounce_multi: RTL and testbench



---
 rtl/sync_debounce_multi.sv | 120 ++++++++++++
 tb/tb_sync_debounce_multi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce_multi
// Purpose  : Per-channel DEPTH-stage synchroniser followed by a stability
//            counter debouncer, giving clean levels plus rise/fall/any pulses.
//            Long-press detection is built only when SYNC_DEBOUNCE_HOLD_EN
//            is defined; otherwise hold_out/hold_pulse are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sync_debounce_multi #(
    parameter int   CHANNELS      = 4,
    parameter int   DEPTH         = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_LEVEL   = 1'b0,
    parameter int   HOLD_CYCLES   = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_sig,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_out,
    output logic [CHANNELS-1:0] fall_out,
    output logic                any_change,
    output logic [CHANNELS-1:0] hold_out,
    output logic [CHANNELS-1:0] hold_pulse
);

    localparam int                 c_CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);
`ifdef SYNC_DEBOUNCE_HOLD_EN
    localparam int                  c_HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_CYCLES);
`endif

    if (CHANNELS < 1 || DEPTH < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("sync_debounce_multi: parameter out of range");
    end

    // One bit per channel: the debounced level flips on this edge.
    logic [CHANNELS-1:0] w_accept;
    logic                r_any;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [DEPTH-1:0]   r_sync;
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_level;
        logic               r_rise;
        logic               r_fall;
        logic               w_synced;

        assign w_synced    = r_sync[DEPTH-1];
        assign w_accept[c] = (w_synced != r_level) && (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync  <= {DEPTH{RESET_LEVEL}};
                r_cnt   <= '0;
                r_level <= RESET_LEVEL;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_sync <= {r_sync[DEPTH-2:0], in_sig[c]};
                r_rise <= w_accept[c] && w_synced;
                r_fall <= w_accept[c] && !w_synced;
                if (w_synced == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept[c]) begin
                    r_level <= w_synced;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end

        assign level_out[c] = r_level;
        assign rise_out[c]  = r_rise;
        assign fall_out[c]  = r_fall;

`ifdef SYNC_DEBOUNCE_HOLD_EN
        logic [c_HOLD_W-1:0] r_hcnt;
        logic [c_HOLD_W-1:0] w_hcnt_nxt;
        logic                r_hold;
        logic                r_hpulse;

        assign w_hcnt_nxt = (r_hcnt == c_HOLD_MAX) ? r_hcnt : r_hcnt + c_HOLD_W'(1);

        // While high, an accepted change can only be a fall, so it clears hold.
        always_ff @(posedge clk) begin
            if (rst || !r_level || w_accept[c]) begin
                r_hcnt   <= '0;
                r_hold   <= 1'b0;
                r_hpulse <= 1'b0;
            end else begin
                r_hcnt   <= w_hcnt_nxt;
                r_hold   <= (w_hcnt_nxt == c_HOLD_MAX);
                r_hpulse <= (w_hcnt_nxt == c_HOLD_MAX) && !r_hold;
            end
        end

        assign hold_out[c]   = r_hold;
        assign hold_pulse[c] = r_hpulse;
`else
        assign hold_out[c]   = 1'b0;
        assign hold_pulse[c] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_accept;
        end
    end

    assign any_change = r_any;

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_debounce_multi
// Purpose  : Directed self-checking bench for sync_debounce_multi
//            (DEPTH=2, STABLE_CYCLES=4, HOLD_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_debounce_multi;

`ifdef SYNC_DEBOUNCE_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_sig = 4'b0000;
    logic [3:0] level_out, rise_out, fall_out, hold_out, hold_pulse;
    logic       any_change;

    logic [3:0] in_one = 4'b1111;
    logic [3:0] level1, rise1, fall1, hold1, hpulse1;
    logic       any1;

    int          checks = 0;
    int          errors = 0;
    logic [20:0] got, exp;
    logic [12:0] got1, exp1;

    always #5 clk = ~clk;

    sync_debounce_multi #(
        .CHANNELS(4), .DEPTH(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .HOLD_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .in_sig(in_sig),
        .level_out(level_out), .rise_out(rise_out), .fall_out(fall_out),
        .any_change(any_change), .hold_out(hold_out), .hold_pulse(hold_pulse)
    );

    sync_debounce_multi #(
        .CHANNELS(4), .DEPTH(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b1), .HOLD_CYCLES(8)
    ) dut1 (
        .clk(clk), .rst(rst), .in_sig(in_one),
        .level_out(level1), .rise_out(rise1), .fall_out(fall1),
        .any_change(any1), .hold_out(hold1), .hold_pulse(hpulse1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_sig = 4'b0000;
        tick();
        tick();
        got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
        exp = '0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_rl0 got %b expected %b", got, exp);
        end
        got1 = {level1, rise1, fall1, any1};
        exp1 = {4'b1111, 4'b0000, 4'b0000, 1'b0};
        checks++;
        if (got1 !== exp1) begin
            errors++;
            $display("FAIL reset_rl1 got %b expected %b", got1, exp1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_rise();
        logic [3:0] e_lvl, e_rise, e_fall;
        in_sig = 4'b0001;
        for (int t = 1; t <= 8; t++) begin
            tick();
            e_lvl  = (t >= 6) ? 4'b0001 : 4'b0000;
            e_rise = (t == 6) ? 4'b0001 : 4'b0000;
            got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
            exp = {e_lvl, e_rise, 4'b0000, e_rise != 4'b0000, 4'b0000, 4'b0000};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_rise t=%0d got %b expected %b", t, got, exp);
            end
        end
        in_sig = 4'b0000;
        for (int t = 1; t <= 7; t++) begin
            tick();
            e_lvl  = (t >= 6) ? 4'b0000 : 4'b0001;
            e_fall = (t == 6) ? 4'b0001 : 4'b0000;
            got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
            exp = {e_lvl, 4'b0000, e_fall, e_fall != 4'b0000, 4'b0000, 4'b0000};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_fall t=%0d got %b expected %b", t, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] e_lvl, e_rise, e_fall;
        // Three-cycle pulse must be rejected entirely.
        for (int t = 1; t <= 12; t++) begin
            in_sig = (t <= 3) ? 4'b0010 : 4'b0000;
            tick();
            got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
            exp = '0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL glitch3 t=%0d got %b expected %b", t, got, exp);
            end
        end
        // Four-cycle pulse is accepted, then debounced back low.
        for (int t = 1; t <= 14; t++) begin
            in_sig = (t <= 4) ? 4'b0010 : 4'b0000;
            tick();
            e_lvl  = (t >= 6 && t <= 9) ? 4'b0010 : 4'b0000;
            e_rise = (t == 6) ? 4'b0010 : 4'b0000;
            e_fall = (t == 10) ? 4'b0010 : 4'b0000;
            got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
            exp = {e_lvl, e_rise, e_fall, (e_rise | e_fall) != 4'b0000, 4'b0000, 4'b0000};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL glitch4 t=%0d got %b expected %b", t, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e_lvl, e_rise, e_fall;
        in_sig = 4'b0100;
        for (int t = 1; t <= 7; t++) tick();
        got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
        exp = {4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL simul_setup got %b expected %b", got, exp);
        end
        in_sig = 4'b1000;
        for (int t = 1; t <= 8; t++) begin
            tick();
            e_lvl  = (t >= 6) ? 4'b1000 : 4'b0100;
            e_rise = (t == 6) ? 4'b1000 : 4'b0000;
            e_fall = (t == 6) ? 4'b0100 : 4'b0000;
            got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
            exp = {e_lvl, e_rise, e_fall, t == 6, 4'b0000, 4'b0000};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simul t=%0d got %b expected %b", t, got, exp);
            end
        end
        in_sig = 4'b0000;
        for (int t = 1; t <= 8; t++) tick();
    endtask

    task automatic test_reset_mid_count();
        logic [3:0] e_lvl, e_rise;
        in_sig = 4'b0001;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
        exp = '0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid got %b expected %b", got, exp);
        end
        rst = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            e_lvl  = (t >= 6) ? 4'b0001 : 4'b0000;
            e_rise = (t == 6) ? 4'b0001 : 4'b0000;
            got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
            exp = {e_lvl, e_rise, 4'b0000, e_rise != 4'b0000, 4'b0000, 4'b0000};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_reset t=%0d got %b expected %b", t, got, exp);
            end
        end
        in_sig = 4'b0000;
        for (int t = 1; t <= 8; t++) tick();
    endtask

    task automatic test_reset_level_one();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 11; t++) begin
            tick();
            got1 = {level1, rise1, fall1, any1};
            exp1 = {4'b1111, 4'b0000, 4'b0000, 1'b0};
            checks++;
            if (got1 !== exp1) begin
                errors++;
                $display("FAIL rl1_release t=%0d got %b expected %b", t, got1, exp1);
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] e_lvl, e_rise, e_fall, e_hold, e_hp;
        in_sig = 4'b0001;
        for (int t = 1; t <= 20; t++) begin
            tick();
            e_lvl  = (t >= 6) ? 4'b0001 : 4'b0000;
            e_rise = (t == 6) ? 4'b0001 : 4'b0000;
            e_hold = (HOLD_EN && t >= 14) ? 4'b0001 : 4'b0000;
            e_hp   = (HOLD_EN && t == 14) ? 4'b0001 : 4'b0000;
            got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
            exp = {e_lvl, e_rise, 4'b0000, e_rise != 4'b0000, e_hold, e_hp};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold_on t=%0d got %b expected %b", t, got, exp);
            end
        end
        in_sig = 4'b0000;
        for (int t = 1; t <= 7; t++) begin
            tick();
            e_lvl  = (t >= 6) ? 4'b0000 : 4'b0001;
            e_fall = (t == 6) ? 4'b0001 : 4'b0000;
            e_hold = (HOLD_EN && t < 6) ? 4'b0001 : 4'b0000;
            got = {level_out, rise_out, fall_out, any_change, hold_out, hold_pulse};
            exp = {e_lvl, 4'b0000, e_fall, e_fall != 4'b0000, e_hold, 4'b0000};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold_off t=%0d got %b expected %b", t, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        test_reset_level_one();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
